sigma_core_memory: RTL and testbench

Word-addressed main-memory responder that serves the CPU's memory port: it accepts one read or write request at a time, models a core-memory cycle (access latency, then a restore period), and returns read data with a one-cycle acknowledge. It sits between the CPU's address/data lines and the backing storage array, using the CPU's big-endian bit numbering: data bits [0:31], bit 0 is the MSB; address bits [15:31].

---
 rtl/sigma_core_memory.sv | 119 +++++++++++
 tb/tb_sigma_core_memory.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sigma_core_memory.sv
// Word-addressed core-memory responder: one request at a time, fixed access
// latency, a single-cycle acknowledge, then a restore period before going idle.
module sigma_core_memory #(
  parameter int DEPTH_LOG2     = 12,
  parameter int READ_LATENCY   = 2,
  parameter int RESTORE_CYCLES = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         req,
  input  logic         write,
  input  logic [15:31] address,
  input  logic [0:31]  write_data,
  input  logic [0:3]   byte_enable,
  output logic         ready,
  output logic         ack,
  output logic         data_valid,
  output logic [0:31]  data_out,
  output logic         address_error
);

  localparam int DEPTH   = 1 << DEPTH_LOG2;
  localparam int LAT_M1  = READ_LATENCY - 1;
  localparam int CNT_MAX = (LAT_M1 > RESTORE_CYCLES) ? LAT_M1 : RESTORE_CYCLES;
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
  localparam bit HAS_RESTORE = (RESTORE_CYCLES > 0);
  localparam logic [CNT_W-1:0] LAT_LOAD     = CNT_W'(LAT_M1);
  localparam logic [CNT_W-1:0] RESTORE_LOAD = CNT_W'(RESTORE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, RESTORE} state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  count;
  logic              lat_write;
  logic [15:31]      lat_address;
  logic [0:31]       lat_data;
  logic [0:3]        lat_be;
  logic [DEPTH_LOG2-1:0] index;
  logic              in_range;
  logic              access_edge;

  logic [0:31] mem [0:DEPTH-1];

  // Any set bit above the implemented index field is an out-of-range access.
  assign in_range    = ((32'(lat_address) >> DEPTH_LOG2) == 32'd0);
  assign index       = lat_address[32-DEPTH_LOG2:31];
  assign access_edge = (state == ACCESS) && (count == '0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = ACCESS;
      ACCESS:  if (count == '0) next_state = DONE;
      DONE:    next_state = HAS_RESTORE ? RESTORE : IDLE;
      RESTORE: if (count == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ready         = (state == IDLE);
    ack           = (state == DONE);
    data_valid    = (state == DONE) && !lat_write;
    address_error = (state == DONE) && !in_range;
  end

  // The one counter is reused for the access latency and the restore period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count       <= '0;
      lat_write   <= 1'b0;
      lat_address <= '0;
      lat_data    <= '0;
      lat_be      <= '0;
      data_out    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat_write   <= write;
            lat_address <= address;
            lat_data    <= write_data;
            lat_be      <= byte_enable;
            count       <= LAT_LOAD;
          end
        end
        ACCESS: begin
          if (count == '0) begin
            if (!lat_write) data_out <= in_range ? mem[index] : '0;
          end else begin
            count <= count - 1'b1;
          end
        end
        DONE: count <= RESTORE_LOAD;
        RESTORE: if (count != '0) count <= count - 1'b1;
        default: count <= '0;
      endcase
    end
  end

  // Storage is never reset; reset forces IDLE, so an aborted write never lands.
  always_ff @(posedge clock) begin
    if (access_edge && lat_write && in_range) begin
      for (int lane = 0; lane < 4; lane++) begin
        if (lat_be[lane]) mem[index][8*lane +: 8] <= lat_data[8*lane +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sigma_core_memory.sv
// Self-checking bench for sigma_core_memory: directed scenarios plus random
// traffic against a word-array reference model, and a latency/restore sweep.
module tb_sigma_core_memory;

  logic        clock;
  logic        reset;
  logic        req;
  logic        write;
  logic [16:0] address;
  logic [31:0] write_data;
  logic [3:0]  byte_enable;
  logic        ready;
  logic        ack;
  logic        data_valid;
  logic [31:0] data_out;
  logic        address_error;

  logic        req_sweep;
  logic        ready_fast, ack_fast, dv_fast, ae_fast;
  logic [31:0] dout_fast;
  logic        ready_slow, ack_slow, dv_slow, ae_slow;
  logic [31:0] dout_slow;

  int passed = 0;
  int total  = 0;
  logic [31:0] model_mem [0:4095];
  logic [31:0] last_read;

  sigma_core_memory dut (
    .clock(clock), .reset(reset), .req(req), .write(write), .address(address),
    .write_data(write_data), .byte_enable(byte_enable), .ready(ready), .ack(ack),
    .data_valid(data_valid), .data_out(data_out), .address_error(address_error)
  );

  sigma_core_memory #(.DEPTH_LOG2(12), .READ_LATENCY(1), .RESTORE_CYCLES(0)) dut_fast (
    .clock(clock), .reset(reset), .req(req_sweep), .write(1'b0), .address(17'h01000),
    .write_data(32'h0), .byte_enable(4'h0), .ready(ready_fast), .ack(ack_fast),
    .data_valid(dv_fast), .data_out(dout_fast), .address_error(ae_fast)
  );

  sigma_core_memory #(.DEPTH_LOG2(12), .READ_LATENCY(5), .RESTORE_CYCLES(3)) dut_slow (
    .clock(clock), .reset(reset), .req(req_sweep), .write(1'b0), .address(17'h01000),
    .write_data(32'h0), .byte_enable(4'h0), .ready(ready_slow), .ack(ack_slow),
    .data_valid(dv_slow), .data_out(dout_slow), .address_error(ae_slow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, need finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic void model_write(input logic [16:0] a, input logic [31:0] d, input logic [3:0] be);
    if (a < 17'd4096) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) model_mem[a[11:0]][8*i +: 8] = d[8*i +: 8];
      end
    end
  endfunction

  // Issues one request once the memory is ready and returns what the ack cycle showed.
  task automatic run_txn(input logic wr, input logic [16:0] a, input logic [31:0] d,
                         input logic [3:0] be, output int lat, output logic got_ack,
                         output logic dv, output logic ae, output logic [31:0] dout);
    int guard = 0;
    while (ready !== 1'b1 && guard < 30) begin
      step();
      guard++;
    end
    write = wr; address = a; write_data = d; byte_enable = be; req = 1'b1;
    step();
    req = 1'b0;
    got_ack = 1'b0; lat = 0; dv = 1'b0; ae = 1'b0; dout = '0;
    for (int i = 1; i <= 30 && !got_ack; i++) begin
      step();
      if (ack === 1'b1) begin
        got_ack = 1'b1; lat = i; dv = data_valid; ae = address_error; dout = data_out;
      end
    end
  endtask

  // Cycle c is the interval after sweep edge c; req is held high from edge 1 on.
  function automatic void sweep_model(input int c, input int rl, input int rc,
                                      output logic exp_ack, output logic exp_ready);
    int t = 1;
    exp_ack = 1'b0;
    exp_ready = 1'b1;
    while (t <= c) begin
      if (c <= t + rl + rc) begin
        exp_ready = 1'b0;
        exp_ack = (c == t + rl);
      end
      t = t + rl + rc + 2;
    end
  endfunction

  task automatic test_reset();
    reset = 1'b0; req = 1'b0; write = 1'b0; address = '0; write_data = '0;
    byte_enable = '0; req_sweep = 1'b0;
    #3;
    total++; if (ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b need 1", ready); else passed++;
    total++; if (ack !== 1'b0) $display("[TB] FAIL reset_ack: got %b need 0", ack); else passed++;
    total++; if (data_valid !== 1'b0) $display("[TB] FAIL reset_dv: got %b need 0", data_valid); else passed++;
    total++; if (address_error !== 1'b0) $display("[TB] FAIL reset_ae: got %b need 0", address_error); else passed++;
    total++; if (data_out !== 32'h0) $display("[TB] FAIL reset_dout: got %h need 0", data_out); else passed++;
    step(); step();
    reset = 1'b1;
    last_read = 32'h0;
    for (int i = 0; i < 4; i++) begin
      step();
      total++; if (ack !== 1'b0 || ready !== 1'b1)
        $display("[TB] FAIL idle_after_reset: got ack=%b ready=%b need ack=0 ready=1", ack, ready);
      else passed++;
    end
  endtask

  task automatic test_write_read();
    int lat; logic got, dv, ae; logic [31:0] dout;
    while (ready !== 1'b1) step();
    write = 1'b1; address = 17'h00010; write_data = 32'h12345678; byte_enable = 4'hF; req = 1'b1;
    step();
    req = 1'b0;
    model_write(17'h00010, 32'h12345678, 4'hF);
    for (int c = 0; c < 6; c++) begin
      total++; if (ack !== (c == 2) || ready !== (c >= 4))
        $display("[TB] FAIL write_timeline: cycle %0d got ack=%b ready=%b need ack=%b ready=%b",
                 c, ack, ready, (c == 2), (c >= 4));
      else passed++;
      step();
    end
    total++; if (data_out !== last_read) $display("[TB] FAIL write_keeps_dout: got %h need %h", data_out, last_read); else passed++;
    run_txn(1'b0, 17'h00010, 32'h0, 4'h0, lat, got, dv, ae, dout);
    total++; if (lat !== 2) $display("[TB] FAIL read_latency: got %0d need 2", lat); else passed++;
    total++; if (dv !== 1'b1 || ae !== 1'b0) $display("[TB] FAIL read_flags: got dv=%b ae=%b need dv=1 ae=0", dv, ae); else passed++;
    total++; if (dout !== 32'h12345678) $display("[TB] FAIL read_data: got %h need 12345678", dout); else passed++;
    last_read = 32'h12345678;
  endtask

  task automatic test_byte_lanes();
    int lat; logic got, dv, ae; logic [31:0] dout;
    run_txn(1'b1, 17'h00010, 32'hAABBCCDD, 4'b0101, lat, got, dv, ae, dout);
    model_write(17'h00010, 32'hAABBCCDD, 4'b0101);
    total++; if (got !== 1'b1 || dv !== 1'b0) $display("[TB] FAIL lane_write_ack: got ack=%b dv=%b need ack=1 dv=0", got, dv); else passed++;
    run_txn(1'b0, 17'h00010, 32'h0, 4'h0, lat, got, dv, ae, dout);
    total++; if (dout !== 32'h12BB56DD) $display("[TB] FAIL lane_merge: got %h need 12bb56dd", dout); else passed++;
    run_txn(1'b1, 17'h00010, 32'hFFFFFFFF, 4'b0000, lat, got, dv, ae, dout);
    total++; if (got !== 1'b1) $display("[TB] FAIL empty_mask_ack: got %b need 1", got); else passed++;
    run_txn(1'b0, 17'h00010, 32'h0, 4'h0, lat, got, dv, ae, dout);
    total++; if (dout !== 32'h12BB56DD) $display("[TB] FAIL empty_mask_data: got %h need 12bb56dd", dout); else passed++;
    last_read = 32'h12BB56DD;
  endtask

  task automatic test_out_of_range();
    int lat; logic got, dv, ae; logic [31:0] dout;
    run_txn(1'b1, 17'h00000, 32'h0BADF00D, 4'hF, lat, got, dv, ae, dout);
    model_write(17'h00000, 32'h0BADF00D, 4'hF);
    run_txn(1'b0, 17'h01000, 32'h0, 4'h0, lat, got, dv, ae, dout);
    total++; if (got !== 1'b1 || dv !== 1'b1 || ae !== 1'b1)
      $display("[TB] FAIL oor_read_flags: got ack=%b dv=%b ae=%b need 1 1 1", got, dv, ae);
    else passed++;
    total++; if (dout !== 32'h0) $display("[TB] FAIL oor_read_data: got %h need 0", dout); else passed++;
    run_txn(1'b1, 17'h01000, 32'hFFFFFFFF, 4'hF, lat, got, dv, ae, dout);
    total++; if (ae !== 1'b1 || dv !== 1'b0) $display("[TB] FAIL oor_write_flags: got ae=%b dv=%b need ae=1 dv=0", ae, dv); else passed++;
    run_txn(1'b0, 17'h00000, 32'h0, 4'h0, lat, got, dv, ae, dout);
    total++; if (dout !== 32'h0BADF00D || ae !== 1'b0)
      $display("[TB] FAIL oor_no_wrap: got %h ae=%b need 0badf00d ae=0", dout, ae);
    else passed++;
    run_txn(1'b0, 17'h10000, 32'h0, 4'h0, lat, got, dv, ae, dout);
    total++; if (ae !== 1'b1 || dout !== 32'h0) $display("[TB] FAIL oor_top_bit: got ae=%b data %h need ae=1 data 0", ae, dout); else passed++;
    last_read = 32'h0;
  endtask

  task automatic test_busy_ignore();
    int acks = 0;
    while (ready !== 1'b1) step();
    write = 1'b0; address = 17'h00010; req = 1'b1;
    step();
    req = 1'b0;
    #2 req = 1'b1;
    step();
    req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (ack === 1'b1) acks++;
      step();
    end
    total++; if (acks !== 1) $display("[TB] FAIL busy_ignore: got %0d acks need 1", acks); else passed++;
    total++; if (data_out !== model_mem[16]) $display("[TB] FAIL busy_read_data: got %h need %h", data_out, model_mem[16]); else passed++;
    last_read = model_mem[16];
  endtask

  task automatic test_abort();
    int lat; int acks = 0; logic got, dv, ae; logic [31:0] dout;
    run_txn(1'b1, 17'h00020, 32'h11112222, 4'hF, lat, got, dv, ae, dout);
    model_write(17'h00020, 32'h11112222, 4'hF);
    while (ready !== 1'b1) step();
    write = 1'b1; address = 17'h00020; write_data = 32'h99998888; byte_enable = 4'hF; req = 1'b1;
    step();
    req = 1'b0;
    #2 reset = 1'b0;
    #1;
    total++; if (ready !== 1'b1 || ack !== 1'b0 || data_out !== 32'h0)
      $display("[TB] FAIL async_reset: got ready=%b ack=%b data %h need 1 0 0", ready, ack, data_out);
    else passed++;
    step(); step();
    #2 reset = 1'b1;
    last_read = 32'h0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ack === 1'b1) acks++;
    end
    total++; if (acks !== 0) $display("[TB] FAIL abort_no_ack: got %0d acks need 0", acks); else passed++;
    run_txn(1'b0, 17'h00020, 32'h0, 4'h0, lat, got, dv, ae, dout);
    total++; if (dout !== 32'h11112222) $display("[TB] FAIL abort_no_write: got %h need 11112222", dout); else passed++;
    last_read = 32'h11112222;
  endtask

  task automatic test_random();
    int lat; logic got, dv, ae; logic [31:0] dout;
    logic wr; logic [16:0] a; logic [31:0] d; logic [3:0] be; logic exp_ae;
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      run_txn(1'b1, 17'(i), d, 4'hF, lat, got, dv, ae, dout);
      model_write(17'(i), d, 4'hF);
    end
    for (int n = 0; n < 40; n++) begin
      a  = ($urandom_range(0, 7) == 0) ? 17'(32'h1000 + $urandom_range(0, 15)) : 17'($urandom_range(0, 15));
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      be = 4'($urandom_range(0, 15));
      exp_ae = (a >= 17'd4096);
      run_txn(wr, a, d, be, lat, got, dv, ae, dout);
      total++; if (lat !== 2 || ae !== exp_ae || dv !== !wr)
        $display("[TB] FAIL rand_flags: txn %0d got lat=%0d ae=%b dv=%b need lat=2 ae=%b dv=%b",
                 n, lat, ae, dv, exp_ae, !wr);
      else passed++;
      if (wr) begin
        model_write(a, d, be);
      end else begin
        last_read = exp_ae ? 32'h0 : model_mem[a[11:0]];
      end
      total++; if (dout !== last_read)
        $display("[TB] FAIL rand_data: txn %0d addr %h got %h need %h", n, a, dout, last_read);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    logic ea, er;
    while (ready !== 1'b1 || ready_fast !== 1'b1 || ready_slow !== 1'b1) step();
    req_sweep = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      sweep_model(c, 1, 0, ea, er);
      total++; if (ack_fast !== ea || ready_fast !== er || dv_fast !== ea || ae_fast !== ea || dout_fast !== 32'h0)
        $display("[TB] FAIL sweep_fast: cycle %0d got ack=%b ready=%b dv=%b ae=%b need ack=%b ready=%b",
                 c, ack_fast, ready_fast, dv_fast, ae_fast, ea, er);
      else passed++;
      sweep_model(c, 5, 3, ea, er);
      total++; if (ack_slow !== ea || ready_slow !== er || dv_slow !== ea || ae_slow !== ea || dout_slow !== 32'h0)
        $display("[TB] FAIL sweep_slow: cycle %0d got ack=%b ready=%b dv=%b ae=%b need ack=%b ready=%b",
                 c, ack_slow, ready_slow, dv_slow, ae_slow, ea, er);
      else passed++;
    end
    req_sweep = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_out_of_range();
    test_busy_ignore();
    test_abort();
    test_random();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
